// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants, types and helpers for the 5-stage pipeline hazard controller.
package pipeline_pkg;

  // EX operand forward-select encodings
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  // Architectural zero register; it is never a real producer
  localparam logic [4:0] REG_X0 = 5'd0;

  // RUN: normal flow; MC_WAIT: pipeline frozen behind the iterative EX unit
  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

  // A destination feeds a source only when it is a real register (x0 never matches)
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and controller-side stall/flush/forward outputs.
// master = pipeline datapath, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       RS1_D;
  logic [4:0]       RS2_D;
  logic [4:0]       RS1_E;
  logic [4:0]       RS2_E;
  logic [4:0]       RD_E;
  logic [4:0]       RD_M;
  logic [4:0]       RD_W;
  logic             RegWriteE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             ResultSrcE;
  logic             PCSrcE;
  logic             MultiCycleE;
  logic             MC_Done;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             MC_Timeout;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
    output PCSrcE, MultiCycleE, MC_Done,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  MC_Timeout, StallCount
  );

  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
    input  PCSrcE, MultiCycleE, MC_Done,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output MC_Timeout, StallCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Combinational forward select for one EX operand; instantiated once per operand.
module hazard_fwd_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  // M holds the younger result, so it takes priority over W
  always_comb begin
    fwd_sel = FWD_NONE;
    if (reg_write_m && reg_match(rd_m, rs_e)) begin
      fwd_sel = FWD_M;
    end else if (reg_write_w && reg_match(rd_w, rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: operand forwarding, load-use stalls,
// taken-branch flushes and freezes while the iterative EX unit is busy, plus a
// saturating count of fetch-stall cycles.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int                  MC_CNT_W      = $clog2(MC_TIMEOUT) + 1;
  localparam logic [MC_CNT_W-1:0] MC_LIMIT      = MC_CNT_W'(MC_TIMEOUT);
  localparam logic [CNT_W-1:0]    STALL_CNT_MAX = '1;

  hz_state_t           state;
  logic [MC_CNT_W-1:0] mc_cnt;
  logic [CNT_W-1:0]    stall_count;
  logic                mc_timeout;

  logic                stall_f;
  logic                stall_d;
  logic                stall_e;
  logic                flush_d;
  logic                flush_e;
  logic                flush_m;
  logic                mc_enter;
  logic                mc_exit_done;
  logic                mc_exit_timeout;
  logic                load_use;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;

  hazard_fwd_sel u_fwd_a (
    .rs_e        (hz.RS1_E),
    .rd_m        (hz.RD_M),
    .rd_w        (hz.RD_W),
    .reg_write_m (hz.RegWriteM),
    .reg_write_w (hz.RegWriteW),
    .fwd_sel     (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_e        (hz.RS2_E),
    .rd_m        (hz.RD_M),
    .rd_w        (hz.RD_W),
    .reg_write_m (hz.RegWriteM),
    .reg_write_w (hz.RegWriteW),
    .fwd_sel     (fwd_b)
  );

  // A load in E whose destination is read by the instruction in D cannot be forwarded in time
  assign load_use = hz.ResultSrcE && hz.RegWriteE &&
                    (reg_match(hz.RD_E, hz.RS1_D) || reg_match(hz.RD_E, hz.RS2_D));

  // Stall/flush decisions are combinational from state and inputs so they act in the same cycle
  always_comb begin
    stall_f         = 1'b0;
    stall_d         = 1'b0;
    stall_e         = 1'b0;
    flush_d         = 1'b0;
    flush_e         = 1'b0;
    flush_m         = 1'b0;
    mc_enter        = 1'b0;
    mc_exit_done    = 1'b0;
    mc_exit_timeout = 1'b0;
    case (state)
      RUN: begin
        if (hz.PCSrcE) begin
          // Taken branch squashes the wrong-path instructions in F-D and D-E
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (hz.MultiCycleE) begin
          // A result already valid this cycle needs no freeze at all
          if (!hz.MC_Done) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
            mc_enter = 1'b1;
          end
        end else if (load_use) begin
          // Hold F and D for one cycle and let the load move on with a bubble behind it
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MC_WAIT: begin
        // E is frozen here, so a branch signal from E is stale and deliberately ignored
        if (hz.MC_Done) begin
          mc_exit_done = 1'b1;
        end else if (mc_cnt == MC_LIMIT) begin
          mc_exit_timeout = 1'b1;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // FSM, wait counter, sticky timeout flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      mc_cnt      <= '0;
      stall_count <= '0;
      mc_timeout  <= 1'b0;
    end else begin
      if (stall_f && (stall_count != STALL_CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (mc_enter) begin
            state  <= MC_WAIT;
            mc_cnt <= MC_CNT_W'(1);
          end
        end
        MC_WAIT: begin
          if (mc_exit_done || mc_exit_timeout) begin
            state  <= RUN;
            mc_cnt <= '0;
          end else begin
            mc_cnt <= mc_cnt + MC_CNT_W'(1);
          end
          if (mc_exit_timeout) begin
            mc_timeout <= 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          mc_cnt <= '0;
        end
      endcase
    end
  end

  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushM     = flush_m;
  assign hz.MC_Timeout = mc_timeout;
  assign hz.StallCount = stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized cycles against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MC_TIMEOUT = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rw_e, rw_m, rw_w, res, pcsrc, multi, done;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, se, fd, fe, fm;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  bit m_in_mc;
  int m_wait;
  bit m_timeout;
  int m_stall_cnt;

  vec_t tbl[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_bus ();

  pipeline_hazard_ctrl #(
    .MC_TIMEOUT (MC_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic in_t mk_in(input logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
                                input logic rw_e, rw_m, rw_w, res, pcsrc, multi, done);
    in_t v;
    v.rs1_d = rs1_d; v.rs2_d = rs2_d; v.rs1_e = rs1_e; v.rs2_e = rs2_e;
    v.rd_e  = rd_e;  v.rd_m  = rd_m;  v.rd_w  = rd_w;
    v.rw_e  = rw_e;  v.rw_m  = rw_m;  v.rw_w  = rw_w;
    v.res   = res;   v.pcsrc = pcsrc; v.multi = multi; v.done = done;
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] fa, fb, input logic sf, sd, se, fd, fe, fm);
    exp_t e;
    e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd; e.se = se; e.fd = fd; e.fe = fe; e.fm = fm;
    return e;
  endfunction

  task automatic addVec(input string name, input in_t i, input exp_t e);
    vec_t v;
    v.name = name;
    v.i    = i;
    v.e    = e;
    tbl.push_back(v);
  endtask

  // Newest producer wins; x0 and non-writing stages never forward
  function automatic logic [1:0] fwdModel(input logic [4:0] rs, input in_t v);
    if (v.rw_m && v.rd_m != 5'd0 && v.rd_m == rs) return 2'b10;
    if (v.rw_w && v.rd_w != 5'd0 && v.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t modelOutputs(input in_t v);
    exp_t e;
    bit   freeze;
    e      = '0;
    e.fa   = fwdModel(v.rs1_e, v);
    e.fb   = fwdModel(v.rs2_e, v);
    freeze = 1'b0;
    if (m_in_mc) begin
      freeze = !(v.done || m_wait == MC_TIMEOUT);
    end else if (v.pcsrc) begin
      e.fd = 1'b1;
      e.fe = 1'b1;
    end else if (v.multi) begin
      freeze = !v.done;
    end else if (v.res && v.rw_e && v.rd_e != 5'd0 && (v.rd_e == v.rs1_d || v.rd_e == v.rs2_d)) begin
      e.sf = 1'b1;
      e.sd = 1'b1;
      e.fe = 1'b1;
    end
    if (freeze) begin
      e.sf = 1'b1;
      e.sd = 1'b1;
      e.se = 1'b1;
      e.fm = 1'b1;
    end
    return e;
  endfunction

  task automatic modelUpdate(input in_t v, input exp_t e);
    if (e.sf && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (m_in_mc) begin
      if (v.done) begin
        m_in_mc = 1'b0;
      end else if (m_wait == MC_TIMEOUT) begin
        m_in_mc   = 1'b0;
        m_timeout = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (!v.pcsrc && v.multi && !v.done) begin
      m_in_mc = 1'b1;
      m_wait  = 1;
    end
  endtask

  task automatic modelReset();
    m_in_mc     = 1'b0;
    m_wait      = 0;
    m_timeout   = 1'b0;
    m_stall_cnt = 0;
  endtask

  task automatic applyStimulus(input in_t v);
    hz_bus.RS1_D       = v.rs1_d;
    hz_bus.RS2_D       = v.rs2_d;
    hz_bus.RS1_E       = v.rs1_e;
    hz_bus.RS2_E       = v.rs2_e;
    hz_bus.RD_E        = v.rd_e;
    hz_bus.RD_M        = v.rd_m;
    hz_bus.RD_W        = v.rd_w;
    hz_bus.RegWriteE   = v.rw_e;
    hz_bus.RegWriteM   = v.rw_m;
    hz_bus.RegWriteW   = v.rw_w;
    hz_bus.ResultSrcE  = v.res;
    hz_bus.PCSrcE      = v.pcsrc;
    hz_bus.MultiCycleE = v.multi;
    hz_bus.MC_Done     = v.done;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, advance model at the rising edge
  task automatic runCycle(input string tag, input in_t v, input bit have_exp, input exp_t want);
    exp_t m;
    applyStimulus(v);
    #1;
    m = modelOutputs(v);
    if (!have_exp) want = m;
    checkOutput({tag, ".ForwardAE"},  32'(hz_bus.ForwardAE),  32'(want.fa));
    checkOutput({tag, ".ForwardBE"},  32'(hz_bus.ForwardBE),  32'(want.fb));
    checkOutput({tag, ".StallF"},     32'(hz_bus.StallF),     32'(want.sf));
    checkOutput({tag, ".StallD"},     32'(hz_bus.StallD),     32'(want.sd));
    checkOutput({tag, ".StallE"},     32'(hz_bus.StallE),     32'(want.se));
    checkOutput({tag, ".FlushD"},     32'(hz_bus.FlushD),     32'(want.fd));
    checkOutput({tag, ".FlushE"},     32'(hz_bus.FlushE),     32'(want.fe));
    checkOutput({tag, ".FlushM"},     32'(hz_bus.FlushM),     32'(want.fm));
    checkOutput({tag, ".StallCount"}, 32'(hz_bus.StallCount), m_stall_cnt);
    checkOutput({tag, ".MC_Timeout"}, 32'(hz_bus.MC_Timeout), 32'(m_timeout));
    @(posedge clk);
    modelUpdate(v, m);
    @(negedge clk);
  endtask

  task automatic applyReset(input in_t v);
    applyStimulus(v);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  function automatic in_t randomIn();
    in_t v;
    v.rs1_d = 5'($urandom_range(0, 7));
    v.rs2_d = 5'($urandom_range(0, 7));
    v.rs1_e = 5'($urandom_range(0, 7));
    v.rs2_e = 5'($urandom_range(0, 7));
    v.rd_e  = 5'($urandom_range(0, 7));
    v.rd_m  = 5'($urandom_range(0, 7));
    v.rd_w  = 5'($urandom_range(0, 7));
    v.rw_e  = 1'($urandom_range(0, 1));
    v.rw_m  = 1'($urandom_range(0, 1));
    v.rw_w  = 1'($urandom_range(0, 1));
    v.res   = ($urandom_range(0, 2) == 0);
    v.pcsrc = ($urandom_range(0, 7) == 0);
    v.multi = ($urandom_range(0, 7) == 0);
    v.done  = ($urandom_range(0, 5) == 0);
    if (v.multi) v.res = 1'b0;
    return v;
  endfunction

  initial begin
    in_t  idle;
    in_t  v;
    exp_t zero;
    exp_t stall_exp;

    idle = '0;
    zero = '0;

    // Reset state
    applyStimulus(idle);
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.StallCount", 32'(hz_bus.StallCount), 0);
    checkOutput("reset.MC_Timeout", 32'(hz_bus.MC_Timeout), 0);
    rst = 1'b0;
    runCycle("reset_idle", idle, 1'b1, zero);

    // Single-cycle behaviour from RUN
    //          rs1d rs2d rs1e rs2e rde rdm rdw rwe rwm rww res pc  mc  done
    addVec("fwd_m_over_w",   mk_in(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0), mk_exp(2'b10, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("fwd_x0",         mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("fwd_w_both",     mk_in(0, 0, 9, 9, 0, 2, 9, 0, 1, 1, 0, 0, 0, 0), mk_exp(2'b01, 2'b01, 0, 0, 0, 0, 0, 0));
    addVec("fwd_mixed",      mk_in(0, 0, 4, 3, 0, 3, 4, 0, 1, 1, 0, 0, 0, 0), mk_exp(2'b01, 2'b10, 0, 0, 0, 0, 0, 0));
    addVec("fwd_no_write",   mk_in(0, 0, 6, 6, 0, 6, 6, 0, 0, 0, 0, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("load_use_rs2",   mk_in(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 1, 1, 0, 0, 1, 0));
    addVec("load_use_rs1",   mk_in(12, 0, 0, 0, 12, 0, 0, 1, 0, 0, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 1, 1, 0, 0, 1, 0));
    addVec("load_x0",        mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("load_no_write",  mk_in(7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("alu_no_stall",   mk_in(7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("load_no_match",  mk_in(8, 9, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec("branch_over_ld", mk_in(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 1, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 1, 1, 0));
    addVec("branch_over_mc", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 1, 1, 0));
    addVec("mc_done_same",   mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    foreach (tbl[k]) runCycle(tbl[k].name, tbl[k].i, 1'b1, tbl[k].e);
    checkOutput("table.StallCount", 32'(hz_bus.StallCount), 2);

    // Iterative op completing on its third frozen cycle; branch in E ignored while frozen
    v = idle;
    v.multi = 1'b1;
    v.rs1_e = 5'd5;
    v.rd_w  = 5'd5;
    v.rw_w  = 1'b1;
    stall_exp = mk_exp(2'b01, 2'b00, 1, 1, 1, 0, 0, 1);
    runCycle("mc_enter", v, 1'b1, stall_exp);
    runCycle("mc_wait1", v, 1'b1, stall_exp);
    v.pcsrc = 1'b1;
    runCycle("mc_wait_branch", v, 1'b1, stall_exp);
    v.pcsrc = 1'b0;
    v.done  = 1'b1;
    runCycle("mc_done", v, 1'b1, mk_exp(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
    runCycle("mc_after_done", idle, 1'b1, zero);
    v = idle;
    v.pcsrc = 1'b1;
    runCycle("run_branch", v, 1'b1, mk_exp(2'b00, 2'b00, 0, 0, 0, 1, 1, 0));
    checkOutput("mc_done.StallCount", 32'(hz_bus.StallCount), 5);
    checkOutput("mc_done.MC_Timeout", 32'(hz_bus.MC_Timeout), 0);

    // Iterative op that never finishes: forced release after the timeout
    v = idle;
    v.multi = 1'b1;
    stall_exp = mk_exp(2'b00, 2'b00, 1, 1, 1, 0, 0, 1);
    for (int k = 1; k <= MC_TIMEOUT; k++) begin
      runCycle($sformatf("mc_to_stall%0d", k), v, 1'b1, stall_exp);
    end
    runCycle("mc_to_release", v, 1'b1, zero);
    checkOutput("mc_timeout_set", 32'(hz_bus.MC_Timeout), 1);
    repeat (3) runCycle("after_timeout", idle, 1'b1, zero);
    checkOutput("mc_timeout_sticky", 32'(hz_bus.MC_Timeout), 1);
    checkOutput("timeout.StallCount", 32'(hz_bus.StallCount), 13);

    // Stall counter saturates at its maximum
    v = mk_in(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    repeat (4) runCycle("sat_load_use", v, 1'b1, mk_exp(2'b00, 2'b00, 1, 1, 0, 0, 1, 0));
    checkOutput("sat.StallCount", 32'(hz_bus.StallCount), CNT_MAX);

    // Reset while frozen beats every other input
    v = idle;
    v.multi = 1'b1;
    runCycle("rst_mc_enter", v, 1'b1, stall_exp);
    runCycle("rst_mc_wait", v, 1'b1, stall_exp);
    v.pcsrc = 1'b1;
    applyReset(v);
    checkOutput("rst_mid.StallCount", 32'(hz_bus.StallCount), 0);
    checkOutput("rst_mid.MC_Timeout", 32'(hz_bus.MC_Timeout), 0);
    runCycle("rst_mid_idle", idle, 1'b1, zero);

    // Randomized cycles against the behavioural model
    for (int n = 0; n < 600; n++) begin
      v = randomIn();
      if ($urandom_range(0, 149) == 0) begin
        applyReset(v);
      end else begin
        runCycle($sformatf("rand%0d", n), v, 1'b0, zero);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
